// File: rtl/spi_peripheral_if.sv
// SPI pad signals plus the controller-facing byte port of spi_peripheral.
// Optional frame_err exists only when SPI_FRAME_ERR_EN is defined.
interface spi_peripheral_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       new_data;
    logic [7:0] din;
    logic [7:0] dout;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    modport slave (
        input  sclk, cs_n, mosi, dout,
        output miso, miso_oe, new_data, din
`ifdef SPI_FRAME_ERR_EN
        , output frame_err
`endif
    );

    modport master (
        output sclk, cs_n, mosi, dout,
        input  miso, miso_oe, new_data, din
`ifdef SPI_FRAME_ERR_EN
        , input frame_err
`endif
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 slave: oversampled pads -> din/new_data, dout -> miso; SPI_FRAME_ERR_EN adds frame_err.
// Latency: new_data one clk after the synchronised 8th sclk rise; miso updates one clk after a synchronised fall.
// Backpressure: none; the SPI master owns timing and the controller must supply dout within LOAD_DELAY.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int LOAD_DELAY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_peripheral_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, warm_sync;
    logic       sclk_d, armed;
    logic       sclk_s, mosi_s, cs_n_s, rise, fall;
    state_t     state_q, state_n;
    logic [2:0] bit_cnt, bit_cnt_n, load_cnt, load_cnt_n;
    logic [6:0] rx_shift, rx_shift_n, tx_shift, tx_shift_n;
    logic [7:0] din_q, din_n;
    logic       new_data_q, new_data_n, miso_q, miso_n;
    logic       frame_err_q, frame_err_n;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;

    // warm_sync marks when cs_sync holds a real pad sample rather than its reset 1s,
    // so a frame already in progress at reset release is not mistaken for a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            cs_sync     <= '1;
            warm_sync   <= '0;
            sclk_d      <= 1'b0;
            armed       <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt     <= 3'd0;
            load_cnt    <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 7'd0;
            din_q       <= 8'h00;
            new_data_q  <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            warm_sync   <= {warm_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_d      <= sclk_s;
            armed       <= armed | (warm_sync[SYNC_STAGES-1] & cs_n_s);
            state_q     <= state_n;
            bit_cnt     <= bit_cnt_n;
            load_cnt    <= load_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            din_q       <= din_n;
            new_data_q  <= new_data_n;
            miso_q      <= miso_n;
            frame_err_q <= frame_err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE:  if (armed && !cs_n_s)           state_n = ST_SHIFT;
            ST_SHIFT: if (rise && bit_cnt == 3'd7)     state_n = ST_LOAD;
            ST_LOAD:  if (load_cnt == 3'd0)            state_n = ST_SHIFT;
            default:                                   state_n = ST_IDLE;
        endcase
        if (cs_n_s)
            state_n = ST_IDLE;
    end

    always_comb begin
        bit_cnt_n   = bit_cnt;
        load_cnt_n  = load_cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        din_n       = din_q;
        new_data_n  = 1'b0;
        miso_n      = miso_q;
        frame_err_n = 1'b0;
        if (cs_n_s) begin
            bit_cnt_n   = 3'd0;
            frame_err_n = (state_q != ST_IDLE) && (bit_cnt != 3'd0);
        end else if (state_q == ST_IDLE) begin
            if (armed) begin
                tx_shift_n = bus.dout[6:0];
                miso_n     = bus.dout[7];
                bit_cnt_n  = 3'd0;
            end
        end else begin
            // Receive path runs in both SHIFT and LOAD so no mosi bit is ever lost.
            if (rise) begin
                rx_shift_n = {rx_shift[5:0], mosi_s};
                bit_cnt_n  = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    din_n      = {rx_shift, mosi_s};
                    new_data_n = 1'b1;
                end
            end
            if (state_q == ST_SHIFT) begin
                if (rise && bit_cnt == 3'd7)
                    load_cnt_n = 3'(LOAD_DELAY);
                if (fall && bit_cnt != 3'd0) begin
                    miso_n     = tx_shift[6];
                    tx_shift_n = {tx_shift[5:0], 1'b0};
                end
            end else if (load_cnt == 3'd0) begin
                tx_shift_n = bus.dout[6:0];
                miso_n     = bus.dout[7];
            end else begin
                load_cnt_n = load_cnt - 3'd1;
            end
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = ~cs_n_s;
    assign bus.new_data = new_data_q;
    assign bus.din      = din_q;
`ifdef SPI_FRAME_ERR_EN
    assign bus.frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: SPI master model at clk = 8x sclk with a new_data monitor.
module tb_spi_peripheral;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_peripheral_if bus ();
    spi_peripheral #(.SYNC_STAGES(2), .LOAD_DELAY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int passed = 0;
    int pulse_cnt = 0;
    int ferr_cnt = 0;
    bit prev_nd = 1'b0;
    bit consec = 1'b0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] mosi_b;
        logic [7:0] dout_b;
        logic [7:0] din_exp;
        logic [7:0] miso_exp;
    } vec_t;
    vec_t tbl[4];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.new_data === 1'b1) begin
                pulse_cnt++;
                rx_q.push_back(bus.din);
                if (prev_nd) consec = 1'b1;
            end
            prev_nd = (bus.new_data === 1'b1);
`ifdef SPI_FRAME_ERR_EN
            if (bus.frame_err === 1'b1) ferr_cnt++;
`endif
        end else begin
            prev_nd = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    // Sends the top nbits of tx MSB first; miso is captured just before each rise.
    // nxt_dout is handed to the controller port after the first rise of the byte.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic [7:0] nxt_dout,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.sclk = 1'b0;
            bus.mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            if (i == 7) bus.dout = nxt_dout;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        bus.sclk = 1'b0;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] got [4];
        logic [7:0] r;
        int base;

        tbl[0] = '{mosi_b: 8'h3C, dout_b: 8'hC3, din_exp: 8'h3C, miso_exp: 8'hC3};
        tbl[1] = '{mosi_b: 8'hFF, dout_b: 8'h00, din_exp: 8'hFF, miso_exp: 8'h00};
        tbl[2] = '{mosi_b: 8'h00, dout_b: 8'hFF, din_exp: 8'h00, miso_exp: 8'hFF};
        tbl[3] = '{mosi_b: 8'hA7, dout_b: 8'h7A, din_exp: 8'hA7, miso_exp: 8'h7A};

        rst_n = 1'b0;
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.dout = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_din", 32'(bus.din), 32'h00);
        chk("reset_new_data", 32'(bus.new_data), 32'h0);
        chk("reset_miso", 32'(bus.miso), 32'h0);
        chk("reset_miso_oe", 32'(bus.miso_oe), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Two-byte frame: chip id A5 on the first byte, 5A from the controller on the second.
        bus.dout = 8'hA5;
        bus.cs_n = 1'b0;
        spi_bits(8'h81, 8, 8'h5A, got[0]);
        spi_bits(8'h00, 8, 8'h11, got[1]);
        chk("t1_miso_oe", 32'(bus.miso_oe), 32'h1);
        end_frame();
        chk("t1_pulses", 32'(pulse_cnt), 32'd2);
        chk("t1_din0", 32'(rx_at(0)), 32'h81);
        chk("t1_miso0", 32'(got[0]), 32'hA5);
        chk("t2_din1", 32'(rx_at(1)), 32'h00);
        chk("t2_miso1", 32'(got[1]), 32'h5A);
        chk("t2_oe_idle", 32'(bus.miso_oe), 32'h0);

        // Partial byte: five bits then deselect.
        bus.dout = 8'h22;
        bus.cs_n = 1'b0;
        spi_bits(8'hF0, 5, 8'h22, r);
        end_frame();
        chk("t3_pulses", 32'(pulse_cnt), 32'd2);
        chk("t3_din_held", 32'(bus.din), 32'h00);
`ifdef SPI_FRAME_ERR_EN
        chk("t3_frame_err", 32'(ferr_cnt), 32'd1);
`endif

        // Back-to-back bytes from the vector table.
        base = pulse_cnt;
        bus.dout = tbl[0].dout_b;
        bus.cs_n = 1'b0;
        for (int k = 0; k < 4; k++)
            spi_bits(tbl[k].mosi_b, 8, (k < 3) ? tbl[k + 1].dout_b : 8'h00, got[k]);
        end_frame();
        chk("t4_pulses", 32'(pulse_cnt - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_din%0d", k), 32'(rx_at(base + k)), 32'(tbl[k].din_exp));
            chk($sformatf("t4_miso%0d", k), 32'(got[k]), 32'(tbl[k].miso_exp));
        end
        chk("t4_single_cycle", 32'(consec), 32'h0);

        // Reset during bit 3; no frame starts until cs_n has been seen high again.
        bus.dout = 8'hEE;
        bus.cs_n = 1'b0;
        spi_bits(8'hB4, 3, 8'hEE, r);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_din", 32'(bus.din), 32'h00);
        chk("t5_rst_new_data", 32'(bus.new_data), 32'h0);
        chk("t5_rst_miso", 32'(bus.miso), 32'h0);
        chk("t5_rst_miso_oe", 32'(bus.miso_oe), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = pulse_cnt;
        spi_bits(8'hC9, 8, 8'hEE, r);
        end_frame();
        chk("t5_no_resume", 32'(pulse_cnt - base), 32'd0);
        bus.dout = 8'h69;
        bus.cs_n = 1'b0;
        spi_bits(8'h96, 8, 8'h00, got[0]);
        end_frame();
        chk("t5_pulses", 32'(pulse_cnt - base), 32'd1);
        chk("t5_din", 32'(rx_at(base)), 32'h96);
        chk("t5_miso", 32'(got[0]), 32'h69);

        // Deselect coincident with the 8th rise discards the byte.
        base = pulse_cnt;
        bus.dout = 8'h33;
        bus.cs_n = 1'b0;
        spi_bits(8'h55, 7, 8'h33, r);
        bus.sclk = 1'b0;
        bus.mosi = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_miso_oe", 32'(bus.miso_oe), 32'h0);
        bus.sclk = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_pulses", 32'(pulse_cnt - base), 32'd0);
        chk("t6_din_held", 32'(bus.din), 32'h96);
`ifdef SPI_FRAME_ERR_EN
        chk("t6_frame_err", 32'(ferr_cnt), 32'd2);
`endif
        bus.dout = 8'hE5;
        bus.cs_n = 1'b0;
        spi_bits(8'h5E, 8, 8'h00, got[0]);
        end_frame();
        chk("t6_recover_din", 32'(rx_at(base)), 32'h5E);
        chk("t6_recover_miso", 32'(got[0]), 32'hE5);
        chk("final_single_cycle", 32'(consec), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
